// File: rtl/vx_stream_router.sv
// 1:N stream router: each beat goes to the output named by sel_in. Every output has
// its own 2-entry elastic buffer (head + skid), so one stalled output never blocks the others.
module vx_stream_router #(
  parameter int NUM_OUTPUTS     = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int LOG_NUM_OUTPUTS = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              valid_in,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic [LOG_NUM_OUTPUTS-1:0]        sel_in,
  output logic                              ready_in,
  output logic [NUM_OUTPUTS-1:0]            valid_out,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] data_out,
  input  logic [NUM_OUTPUTS-1:0]            ready_out,
  output logic                              sel_err
);

  // Handshake: a beat moves on any edge where valid && ready are both high. Once valid
  // is up it holds its data until taken; ready_in depends only on sel_in and registered
  // occupancy, never on ready_out.
  logic [DATA_WIDTH-1:0]  head_q  [NUM_OUTPUTS];
  logic [DATA_WIDTH-1:0]  skid_q  [NUM_OUTPUTS];
  logic [1:0]             count_q [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] sel_hit;
  logic [NUM_OUTPUTS-1:0] push;
  logic [NUM_OUTPUTS-1:0] pop;
  logic [31:0]            sel_wide;
  logic                   sel_oor;

  assign sel_wide = 32'(sel_in);
  // With a single output the select field is ignored entirely.
  assign sel_oor  = (NUM_OUTPUTS > 1) && (sel_wide >= 32'(NUM_OUTPUTS));

  always_comb begin
    ready_in = 1'b1;
    sel_hit  = '0;
    push     = '0;
    pop      = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      sel_hit[i] = (NUM_OUTPUTS == 1) || (sel_wide == 32'(i));
      if (sel_hit[i] && (count_q[i] == 2'd2)) ready_in = 1'b0;
    end
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      push[i] = valid_in && ready_in && sel_hit[i];
      pop[i]  = valid_out[i] && ready_out[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      valid_out[i]                           = (count_q[i] != 2'd0);
      data_out[i*DATA_WIDTH +: DATA_WIDTH]   = head_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        count_q[i] <= 2'd0;
        head_q[i]  <= '0;
        skid_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        case (count_q[i])
          2'd0: begin
            if (push[i]) begin
              head_q[i]  <= data_in;
              count_q[i] <= 2'd1;
            end
          end
          2'd1: begin
            // Push with pop while holding one beat: the new beat goes straight to head.
            if (push[i] && pop[i]) begin
              head_q[i] <= data_in;
            end else if (push[i]) begin
              skid_q[i]  <= data_in;
              count_q[i] <= 2'd2;
            end else if (pop[i]) begin
              count_q[i] <= 2'd0;
            end
          end
          default: begin
            if (pop[i]) begin
              head_q[i]  <= skid_q[i];
              count_q[i] <= 2'd1;
            end
          end
        endcase
      end
    end
  end

  // Out-of-range beats are swallowed; remember that it happened until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_err <= 1'b0;
    end else if (valid_in && ready_in && sel_oor) begin
      sel_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_chk
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
      !(pop[g] && (count_q[g] == 2'd0)));
    a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
      !(push[g] && (count_q[g] == 2'd2)));
    a_hold_stalled: assert property (@(posedge clk) disable iff (!reset)
      (valid_out[g] && !ready_out[g]) |=> (valid_out[g] && $stable(head_q[g])));
  end

endmodule
